// File: rtl/noc_local_inject_arbiter.sv
// Shares one mesh node's local injection port among NUM_REQ requesters with packet-level round-robin; optional watchdog via NOC_INJ_ARB_WATCHDOG_EN.
// Latency: one cycle from header valid to grant, then a combinational pass-through; the next owner is granted on the tail cycle with no bubble.
// Backpressure: sender_ready_i feeds only the owner's req_ready_o; nothing is buffered or dropped.
module noc_local_inject_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int WDT_CYCLES = 256
) (
    input  logic                          noc_clk_i,
    input  logic                          noc_rst_n_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_flit_i,
    input  logic [NUM_REQ-1:0]            req_is_header_i,
    input  logic [NUM_REQ-1:0]            req_is_tail_i,
    output logic                          sender_valid_o,
    input  logic                          sender_ready_i,
    output logic [DATA_WIDTH-1:0]         sender_flit_o,
    output logic                          sender_is_header_o,
    output logic                          sender_is_tail_o,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id_o,
    output logic                          busy_o,
    output logic                          err_orphan_o,
    output logic                          wdt_timeout_o
);

    localparam int IDW = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || WDT_CYCLES < 1) begin : g_param_chk
        $error("noc_local_inject_arbiter: illegal parameter values");
    end

    typedef enum logic {IDLE, LOCK} state_t;

    state_t           state_q;
    logic [IDW-1:0]   grant_q;
    logic [IDW-1:0]   rr_ptr_q;
    logic             err_orphan_q;

    logic [NUM_REQ-1:0] cand;
    logic               cand_any;
    logic [IDW-1:0]     win_id;
    logic               own_xfer;
    logic               tail_xfer;
    logic               orphan;

    // The owner is masked so a header+tail flit cannot re-grant its own requester.
    always_comb begin
        int  idx;
        logic found;
        cand = req_valid_i & req_is_header_i;
        if (state_q == LOCK) begin
            cand[grant_q] = 1'b0;
        end
        cand_any = |cand;
        win_id   = '0;
        found    = 1'b0;
        idx      = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (!found && cand[idx]) begin
                found  = 1'b1;
                win_id = IDW'(idx);
            end
        end
    end

    always_comb begin
        sender_valid_o     = 1'b0;
        sender_flit_o      = '0;
        sender_is_header_o = 1'b0;
        sender_is_tail_o   = 1'b0;
        req_ready_o        = '0;
        if (state_q == LOCK) begin
            sender_valid_o       = req_valid_i[grant_q];
            sender_flit_o        = req_flit_i[grant_q*DATA_WIDTH +: DATA_WIDTH];
            sender_is_header_o   = req_is_header_i[grant_q];
            sender_is_tail_o     = req_is_tail_i[grant_q];
            req_ready_o[grant_q] = sender_ready_i;
        end
    end

    assign own_xfer  = (state_q == LOCK) && req_valid_i[grant_q] && sender_ready_i;
    assign tail_xfer = own_xfer && req_is_tail_i[grant_q];
    assign orphan    = (state_q == IDLE) && (|(req_valid_i & ~req_is_header_i));

`ifdef NOC_INJ_ARB_WATCHDOG_EN
    localparam int WDW = $clog2(WDT_CYCLES + 1);
    localparam logic [WDW-1:0] WDT_LAST = WDW'(WDT_CYCLES - 1);

    logic [WDW-1:0] wdt_cnt_q;
    logic           wdt_timeout_q;
`endif

    always_ff @(posedge noc_clk_i or negedge noc_rst_n_i) begin
        if (!noc_rst_n_i) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            rr_ptr_q      <= IDW'(NUM_REQ - 1);
            err_orphan_q  <= 1'b0;
`ifdef NOC_INJ_ARB_WATCHDOG_EN
            wdt_cnt_q     <= '0;
            wdt_timeout_q <= 1'b0;
`endif
        end else begin
            if (orphan) begin
                err_orphan_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (cand_any) begin
                        grant_q  <= win_id;
                        rr_ptr_q <= win_id;
                        state_q  <= LOCK;
`ifdef NOC_INJ_ARB_WATCHDOG_EN
                        wdt_cnt_q <= '0;
`endif
                    end
                end
                LOCK: begin
                    if (tail_xfer) begin
                        if (cand_any) begin
                            grant_q  <= win_id;
                            rr_ptr_q <= win_id;
                        end else begin
                            state_q <= IDLE;
                        end
`ifdef NOC_INJ_ARB_WATCHDOG_EN
                        wdt_cnt_q <= '0;
                    end else if (own_xfer) begin
                        wdt_cnt_q <= '0;
                    end else if (!req_valid_i[grant_q]) begin
                        // Only a silent owner counts; a stalled sender never starves anyone.
                        if (wdt_cnt_q == WDT_LAST) begin
                            wdt_timeout_q <= 1'b1;
                            state_q       <= IDLE;
                            wdt_cnt_q     <= '0;
                        end else begin
                            wdt_cnt_q <= wdt_cnt_q + WDW'(1);
                        end
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign grant_id_o   = grant_q;
    assign busy_o       = (state_q == LOCK);
    assign err_orphan_o = err_orphan_q;
`ifdef NOC_INJ_ARB_WATCHDOG_EN
    assign wdt_timeout_o = wdt_timeout_q;
`else
    assign wdt_timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_noc_local_inject_arbiter.sv
// Directed bench for noc_local_inject_arbiter: packet ordering, zero-bubble handover, backpressure, orphan flag, reset and watchdog.
module tb_noc_local_inject_arbiter;

    localparam int NR = 4;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*DW-1:0]  req_flit;
    logic [NR-1:0]     req_hdr;
    logic [NR-1:0]     req_tail;
    logic              s_valid;
    logic              s_ready;
    logic [DW-1:0]     s_flit;
    logic              s_hdr;
    logic              s_tail;
    logic [1:0]        grant_id;
    logic              busy;
    logic              err_orphan;
    logic              wdt_timeout;

    int n_err = 0;
    int n_chk = 0;
    int pos [NR];
    int len [NR];

    always #5 clk = ~clk;

    noc_local_inject_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .WDT_CYCLES(256)) dut (
        .noc_clk_i          (clk),
        .noc_rst_n_i        (rst_n),
        .req_valid_i        (req_valid),
        .req_ready_o        (req_ready),
        .req_flit_i         (req_flit),
        .req_is_header_i    (req_hdr),
        .req_is_tail_i      (req_tail),
        .sender_valid_o     (s_valid),
        .sender_ready_i     (s_ready),
        .sender_flit_o      (s_flit),
        .sender_is_header_o (s_hdr),
        .sender_is_tail_o   (s_tail),
        .grant_id_o         (grant_id),
        .busy_o             (busy),
        .err_orphan_o       (err_orphan),
        .wdt_timeout_o      (wdt_timeout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] fl(input int i, input int p);
        return 32'h1000_0000 + 32'(i * 256 + p);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        req_valid = '0;
        req_hdr   = '0;
        req_tail  = '0;
        req_flit  = '0;
        for (int i = 0; i < NR; i++) begin
            pos[i] = 0;
            len[i] = 0;
        end
    endtask

    // Requester model: requester i offers flit pos[i] of a len[i]-flit packet.
    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            req_valid[i]          = (pos[i] < len[i]);
            req_hdr[i]            = (pos[i] == 0);
            req_tail[i]           = (pos[i] == len[i] - 1);
            req_flit[i*DW +: DW]  = fl(i, pos[i]);
        end
    endtask

    task automatic advance(input logic [NR-1:0] acc);
        for (int i = 0; i < NR; i++) begin
            if (acc[i]) pos[i]++;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [NR-1:0] acc;
        int            nacc;

        s_ready = 1'b1;
        clear_in();
        rst_n = 1'b0;
        #3;
        chk("rst_sender_valid", 32'(s_valid), 0);
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_grant", 32'(grant_id), 0);
        chk("rst_err_orphan", 32'(err_orphan), 0);
        chk("rst_wdt", 32'(wdt_timeout), 0);
        chk("rst_flit", s_flit, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single 3-flit packet from requester 0
        len[0] = 3;
        for (int c = 0; c < 5; c++) begin
            drive();
            #1;
            if (c == 0) begin
                chk("t1_idle_valid", 32'(s_valid), 0);
                chk("t1_idle_ready", 32'(req_ready), 0);
            end else if (c <= 3) begin
                chk("t1_valid", 32'(s_valid), 1);
                chk("t1_flit", s_flit, fl(0, c - 1));
                chk("t1_hdr", 32'(s_hdr), (c == 1) ? 1 : 0);
                chk("t1_tail", 32'(s_tail), (c == 3) ? 1 : 0);
                chk("t1_grant", 32'(grant_id), 0);
                chk("t1_busy", 32'(busy), 1);
                chk("t1_ready", 32'(req_ready), 1);
            end else begin
                chk("t1_busy_end", 32'(busy), 0);
                chk("t1_valid_end", 32'(s_valid), 0);
            end
            acc = req_ready & req_valid;
            step();
            advance(acc);
        end

        // All four requesters with 2-flit packets at once, served in order without bubbles
        clear_in();
        do_reset();
        for (int i = 0; i < NR; i++) len[i] = 2;
        for (int c = 0; c < 10; c++) begin
            drive();
            #1;
            if (c == 0) begin
                chk("t2_idle_valid", 32'(s_valid), 0);
            end else if (c <= 8) begin
                chk("t2_valid", 32'(s_valid), 1);
                chk("t2_flit", s_flit, fl((c - 1) / 2, (c - 1) % 2));
                chk("t2_grant", 32'(grant_id), 32'((c - 1) / 2));
                chk("t2_ready", 32'(req_ready), 32'(1) << ((c - 1) / 2));
            end else begin
                chk("t2_busy_end", 32'(busy), 0);
            end
            acc = req_ready & req_valid;
            step();
            advance(acc);
        end

        // 4-flit packet with sender stalled for 5 cycles after the 2nd flit
        clear_in();
        len[0] = 4;
        nacc   = 0;
        for (int c = 0; c < 11; c++) begin
            s_ready = !(c >= 3 && c <= 7);
            drive();
            #1;
            if (c >= 1 && c <= 9) begin
                chk("t3_flit", s_flit, fl(0, (c <= 2) ? c - 1 : ((c <= 8) ? 2 : 3)));
                chk("t3_ready", 32'(req_ready), 32'(s_ready));
            end else if (c == 10) begin
                chk("t3_busy_end", 32'(busy), 0);
            end
            acc  = req_ready & req_valid;
            nacc = nacc + $countones(acc);
            step();
            advance(acc);
        end
        s_ready = 1'b1;
        chk("t3_accept_count", 32'(nacc), 4);

        // Body flit offered while unlocked
        clear_in();
        req_valid[2] = 1'b1;
        req_flit[2*DW +: DW] = fl(2, 1);
        #1;
        chk("t4_ready_pre", 32'(req_ready), 0);
        chk("t4_err_pre", 32'(err_orphan), 0);
        step();
        chk("t4_err_set", 32'(err_orphan), 1);
        chk("t4_ready", 32'(req_ready), 0);
        chk("t4_busy", 32'(busy), 0);
        req_valid = '0;
        repeat (3) step();
        chk("t4_err_sticky", 32'(err_orphan), 1);

        // Requesters 1 and 3 streaming single-flit packets, then reset mid-stream
        do_reset();
        chk("t5_err_cleared", 32'(err_orphan), 0);
        req_valid = 4'b1010;
        req_hdr   = 4'b1010;
        req_tail  = 4'b1010;
        req_flit[1*DW +: DW] = fl(1, 0);
        req_flit[3*DW +: DW] = fl(3, 0);
        for (int c = 0; c < 5; c++) begin
            #1;
            if (c >= 1) begin
                chk("t5_grant", 32'(grant_id), (c % 2 == 1) ? 1 : 3);
                chk("t5_ready", 32'(req_ready), (c % 2 == 1) ? 2 : 8);
                chk("t5_flit", s_flit, fl((c % 2 == 1) ? 1 : 3, 0));
            end
            step();
        end
        req_valid = 4'b1011;
        req_hdr   = 4'b1011;
        req_flit[0*DW +: DW] = fl(0, 0);
        #1;
        chk("t5_busy_before_rst", 32'(busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", 32'(s_valid), 0);
        chk("t5_rst_busy", 32'(busy), 0);
        chk("t5_rst_grant", 32'(grant_id), 0);
        chk("t5_rst_ready", 32'(req_ready), 0);
        chk("t5_rst_flit", s_flit, 0);
        chk("t5_rst_tail", 32'(s_tail), 0);
        step();
        rst_n = 1'b1;
        #1;
        chk("t5_post_rst_idle", 32'(busy), 0);
        step();
        chk("t5_first_grant", 32'(grant_id), 0);
        chk("t5_first_busy", 32'(busy), 1);
        chk("t5_first_flit", s_flit, fl(0, 0));

        // Owner goes silent after its header while requester 1 waits
        clear_in();
        do_reset();
        req_valid = 4'b0011;
        req_hdr   = 4'b0011;
        req_flit[0*DW +: DW] = fl(0, 0);
        req_flit[1*DW +: DW] = fl(1, 0);
        step();
        chk("t6_lock0", 32'(grant_id), 0);
        step();
        req_valid[0] = 1'b0;
        req_hdr[0]   = 1'b0;
`ifdef NOC_INJ_ARB_WATCHDOG_EN
        repeat (255) step();
        chk("t6_busy_before_wdt", 32'(busy), 1);
        chk("t6_wdt_before", 32'(wdt_timeout), 0);
        step();
        chk("t6_wdt_fired", 32'(wdt_timeout), 1);
        chk("t6_busy_after_wdt", 32'(busy), 0);
        step();
        chk("t6_regrant_busy", 32'(busy), 1);
        chk("t6_regrant_id", 32'(grant_id), 1);
        chk("t6_regrant_flit", s_flit, fl(1, 0));
        chk("t6_wdt_sticky", 32'(wdt_timeout), 1);
`else
        repeat (300) step();
        chk("t6_lock_held", 32'(busy), 1);
        chk("t6_lock_owner", 32'(grant_id), 0);
        chk("t6_no_wdt", 32'(wdt_timeout), 0);
        req_valid[0] = 1'b1;
        req_tail[0]  = 1'b1;
        req_flit[0*DW +: DW] = fl(0, 1);
        #1;
        chk("t6_tail_out", 32'(s_tail), 1);
        step();
        chk("t6_next_owner", 32'(grant_id), 1);
        chk("t6_next_busy", 32'(busy), 1);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
